// File: rtl/cpx_accumulate_pkg.sv
// Shared CAF datapath definitions: default sample width, accumulator width
// helper and the output register state encoding.
package cpx_accumulate_pkg;

   localparam int def_sample_bits = 24;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Full-precision accumulator width: summing len values of in_bits bits
   // needs clog2(len) extra bits of headroom.
   function automatic int acc_width(input int in_bits, input int len);
      return in_bits + $clog2(len);
   endfunction

endpackage

// File: rtl/cpx_acc_lane.sv
// Single signed accumulator lane. Clear has priority over add. The
// combinational sum_next (running sum plus the widened input) is exported so
// the top can capture the frame total on the frame-ending sample.
module cpx_acc_lane
   import cpx_accumulate_pkg::*;
#(
   parameter int in_bits  = def_sample_bits,
   parameter int acc_bits = def_sample_bits + 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       add,
   input  logic signed [in_bits-1:0]  x,
   output logic signed [acc_bits-1:0] sum_next
);

   logic signed [acc_bits-1:0] sum_p0;

   // Sign-extend a sample to accumulator width; no rounding or saturation is
   // needed because the width already covers a full frame.
   function automatic logic signed [acc_bits-1:0] widen(input logic signed [in_bits-1:0] v);
      return acc_bits'(v);
   endfunction

   assign sum_next = sum_p0 + widen(x);

   // Running sum: cleared on reset or frame end, otherwise adds accepted samples.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sum_p0 <= '0;
      end else if (add) begin
         sum_p0 <= sum_next;
      end
   end

endmodule

// File: rtl/cpx_accumulate.sv
// Coherent complex integrator: sums `length` consecutive (i, q) samples and
// emits one full-precision complex sum per frame over a valid/ready output.
module cpx_accumulate
   import cpx_accumulate_pkg::*;
#(
   parameter int i_bits = def_sample_bits,
   parameter int q_bits = def_sample_bits,
   parameter int length = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     m_axis_tvalid,
   input  logic signed [i_bits-1:0]                 i,
   input  logic signed [q_bits-1:0]                 q,
   output logic                                     s_axis_tready,
   input  logic                                     m_axis_tready,
   output logic                                     s_axis_tvalid,
   output logic signed [acc_width(i_bits,length)-1:0] acc_i,
   output logic signed [acc_width(q_bits,length)-1:0] acc_q,
   output logic [15:0]                              frame_cnt
);

   localparam int cnt_bits   = $clog2(length + 1);
   localparam int acc_i_bits = acc_width(i_bits, length);
   localparam int acc_q_bits = acc_width(q_bits, length);
   localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(length - 1);

   logic [cnt_bits-1:0]          cnt_p0;
   logic                         last;
   logic                         accept;
   logic                         frame_end;
   logic signed [acc_i_bits-1:0] sum_i_next;
   logic signed [acc_q_bits-1:0] sum_q_next;
   logic signed [acc_i_bits-1:0] acc_i_p1;
   logic signed [acc_q_bits-1:0] acc_q_p1;
   logic [15:0]                  frame_cnt_p1;
   out_state_t                   state_p1;
   out_state_t                   state_next;
   logic                         vld_p1;

   assign last      = (cnt_p0 == last_cnt);
   assign vld_p1    = (state_p1 == FULL);
   // Only the frame-ending sample can stall, and only while the previous sum
   // is still waiting for the consumer.
   assign s_axis_tready = ~rst & ~(vld_p1 & ~m_axis_tready & last);
   assign accept    = m_axis_tvalid & s_axis_tready;
   assign frame_end = accept & last;

   cpx_acc_lane #(.in_bits(i_bits), .acc_bits(acc_i_bits)) u_lane_i (
      .clk      (clk),
      .rst      (rst),
      .clr      (frame_end),
      .add      (accept),
      .x        (i),
      .sum_next (sum_i_next)
   );

   cpx_acc_lane #(.in_bits(q_bits), .acc_bits(acc_q_bits)) u_lane_q (
      .clk      (clk),
      .rst      (rst),
      .clr      (frame_end),
      .add      (accept),
      .x        (q),
      .sum_next (sum_q_next)
   );

   // Sample counter within the current frame; wraps to zero on frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0 <= '0;
      end else if (accept) begin
         cnt_p0 <= last ? '0 : cnt_p0 + cnt_bits'(1);
      end
   end

   // ---- stage p1: output register ----

   // Output register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1 <= EMPTY;
      end else begin
         state_p1 <= state_next;
      end
   end

   // A new frame sum always fills the register (a transfer in the same cycle
   // frees the slot); otherwise a transfer empties it.
   always_comb begin
      state_next = state_p1;
      if (frame_end) begin
         state_next = FULL;
      end else if (vld_p1 && m_axis_tready) begin
         state_next = EMPTY;
      end
   end

   // Frame sum and frame counter capture; held while the sum is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_i_p1     <= '0;
         acc_q_p1     <= '0;
         frame_cnt_p1 <= '0;
      end else if (frame_end) begin
         acc_i_p1     <= sum_i_next;
         acc_q_p1     <= sum_q_next;
         frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
      end
   end

   assign s_axis_tvalid = vld_p1;
   assign acc_i         = acc_i_p1;
   assign acc_q         = acc_q_p1;
   assign frame_cnt     = frame_cnt_p1;

endmodule

// File: doc/cpx_accumulate.md
Name: cpx_accumulate

Overview:
Coherent integrator directly downstream of the complex multiplier in the CAF datapath. Sums consecutive complex products (i, q) over a fixed frame of `length` samples and emits one complex sum per frame. Frames run back to back with no bubble. The output uses the same valid/ready handshake naming as the multiplier so the two chain directly.

Parameters:
- i_bits, 24, width of signed input real part (matches multiplier i_bits)
- q_bits, 24, width of signed input imag part (matches multiplier q_bits)
- length, 16, samples per frame; legal range 1..65535
- cnt_bits, $clog2(length+1), width of sample counter (derived, localparam)
- acc_i_bits, i_bits + $clog2(length), output real width (derived, localparam)
- acc_q_bits, q_bits + $clog2(length), output imag width (derived, localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_axis_tvalid  in  1  upstream sample valid
- i  in  i_bits  signed real input sample
- q  in  q_bits  signed imag input sample
- s_axis_tready  out  1  block can accept a sample this cycle
- m_axis_tready  in  1  downstream ready for the frame sum
- s_axis_tvalid  out  1  frame sum valid
- acc_i  out  acc_i_bits  signed real frame sum
- acc_q  out  acc_q_bits  signed imag frame sum
- frame_cnt  out  16  frames emitted since reset, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: s_axis_tvalid=0, acc_i=0, acc_q=0, frame_cnt=0, internal sum=0, sample count=0.
- Accept: a sample is accepted when m_axis_tvalid & s_axis_tready at a rising edge of clk.
- Input widening: inputs are sign-extended to acc width before adding. Sums are full precision, with no truncation or saturation. Overflow is impossible by construction.
- Accumulation: state is the running sum plus sample count cnt, range 0..length-1.
  - Accepted sample with cnt<length-1: sum <= sum + x; cnt <= cnt+1.
  - Accepted sample with cnt==length-1 (frame end):
    - acc_i/acc_q <= sum + x
    - s_axis_tvalid <= 1
    - frame_cnt <= frame_cnt+1
    - sum <= 0; cnt <= 0
- Latency: the frame sum is visible on the cycle after the final sample is accepted.
- Back to back: the next frame's first sample may be accepted on the very next cycle.
- Output register (states EMPTY / FULL):
  - FULL when s_axis_tvalid=1.
  - A transfer occurs on s_axis_tvalid & m_axis_tready.
  - FULL->EMPTY on transfer with no simultaneous frame end.
  - Simultaneous transfer and frame end: stays FULL with the new sum loaded.
  - acc_i/acc_q are held stable while s_axis_tvalid=1 and m_axis_tready=0.
- Backpressure: s_axis_tready = ~rst & ~(s_axis_tvalid & ~m_axis_tready & cnt==length-1). This is combinational.
  - Mid-frame samples are always accepted. Only the frame-ending sample stalls when the previous sum is still pending.
  - No frame sum is ever dropped or overwritten.
- length=1: every accepted sample is a frame. Output equals the sign-extended input, one cycle later.
- Idle input: when m_axis_tvalid=0, sum and cnt hold; there is no timeout.
- Reset mid-frame: the partial sum and count are discarded and a pending output is cleared. The first post-reset accept starts a fresh frame.
- rst high overrides all handshakes in the same cycle.

Decomposition:
- Shared caf package: clog2-based width helper constants (acc width = in width + clog2(length)) and the default sample width of 24. These are reused by multiplier, accumulator and the later magnitude stage.
- One natural sub-module, cpx_acc_lane. It is a single signed accumulator lane with clear/load/add controls, instantiated twice (i and q).
- Counter, frame-end detect, output register and handshake stay in the top.

Test Plan:
1. Basic sum: length=4; samples i=1,2,3,4 and q=-1,-2,-3,-4; m_axis_tready=1 -> acc_i=10, acc_q=-10, one-cycle s_axis_tvalid pulse the cycle after the 4th accept, frame_cnt=1.
2. Extremes: length=16; i=q=-2^23 for 16 samples -> acc_i=acc_q=-2^27 exactly in 28 bits. Repeat with +2^23-1 -> 134217712.
3. Back to back: length=4; 12 continuous samples i=1 -> three sums of 4 on consecutive frame ends, s_axis_tready never low, frame_cnt=3.
4. Backpressure: hold m_axis_tready=0 after frame 1. Frame 2 samples 1-3 accepted; s_axis_tready drops before sample 4; acc_i holds frame 1 value. Release ready -> frame 1 transfers, sample 4 accepted, frame 2 sum correct.
5. Reset mid-frame: length=4; accept 2 samples of 5, pulse rst, then 4 samples of 1 -> acc_i=4, frame_cnt=1.
6. length=1: i=-7, q=3 -> acc_i=-7, acc_q=3 one cycle later, every cycle with continuous input.
